// File: rtl/ffe_pkg.sv
// Shared number-format constants, PAM2 slicer levels and adaptation state encoding
// for the FFE adaptation path.
package ffe_pkg;

    localparam int FRAC_BITS    = 7;
    localparam int PAM2_POS     = 128;
    localparam int PAM2_NEG     = -128;
    localparam int MU_TRAIN_DEF = 6;
    localparam int MU_TRACK_DEF = 9;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } lms_state_t;

    function automatic logic is_adapting(input lms_state_t s);
        return (s == ST_TRAIN) || (s == ST_TRACK);
    endfunction

endpackage

// File: rtl/lms_tap_update.sv
// One LMS coefficient: step computation, saturating accumulator and truncated output.
// LMS_SIGN_SIGN_EN selects the multiplier-free sign-sign step instead of the full product.
module lms_tap_update
    import ffe_pkg::*;
#(
    parameter int IN_BW    = 11,
    parameter int OUT_BW   = 9,
    parameter int COEF_BW  = 9,
    parameter int ACC_EXT  = 8,
    parameter int MU_TRAIN = MU_TRAIN_DEF,
    parameter int MU_TRACK = MU_TRACK_DEF,
    parameter bit INIT_ONE = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_restart,
    input  logic                      i_upd,
    input  logic                      i_train,
    input  logic signed [OUT_BW:0]    i_err,
    input  logic signed [IN_BW-1:0]   i_x,
    output logic        [COEF_BW-1:0] o_coef
);

    localparam int ACC_BW  = COEF_BW + ACC_EXT;
    localparam int PROD_BW = OUT_BW + 1 + IN_BW;
    localparam int D_BW    = PROD_BW + 1;
    localparam int SUM_BW  = ((D_BW > ACC_BW) ? D_BW : ACC_BW) + 1;

    localparam logic signed [ACC_BW-1:0]  ACC_INIT = INIT_ONE ? ACC_BW'(PAM2_POS << ACC_EXT) : '0;
    localparam logic signed [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic signed [SUM_BW-1:0]  SUM_MAX  = SUM_BW'(ACC_MAX);
    localparam logic signed [SUM_BW-1:0]  SUM_MIN  = SUM_BW'(ACC_MIN);
    localparam logic        [COEF_BW-1:0] COEF_INIT = ACC_INIT[ACC_BW-1:ACC_EXT];

    logic signed [ACC_BW-1:0]  acc_q, acc_nxt;
    logic        [COEF_BW-1:0] coef_q;
    logic signed [D_BW-1:0]    d;
    logic signed [SUM_BW-1:0]  acc_ext, d_ext, sum;

`ifdef LMS_SIGN_SIGN_EN
    localparam logic signed [D_BW-1:0] STEP_TRAIN = D_BW'(1 << (ACC_EXT + FRAC_BITS - MU_TRAIN));
    localparam logic signed [D_BW-1:0] STEP_TRACK = D_BW'(1 << (ACC_EXT + FRAC_BITS - MU_TRACK));

    logic signed [D_BW-1:0] step;

    always_comb begin
        step = i_train ? STEP_TRAIN : STEP_TRACK;
        d    = '0;
        if (i_err != '0 && i_x != '0) begin
            d = (i_err[OUT_BW] ^ i_x[IN_BW-1]) ? -step : step;
        end
    end
`else
    logic signed [PROD_BW-1:0] prod;
    logic signed [D_BW-1:0]    prod2;

    // Doubling aligns the S(.,14) product to the accumulator's 7+ACC_EXT fraction.
    assign prod  = PROD_BW'(i_err) * PROD_BW'(i_x);
    assign prod2 = {prod, 1'b0};
    assign d     = i_train ? (prod2 >>> MU_TRAIN) : (prod2 >>> MU_TRACK);
`endif

    assign acc_ext = SUM_BW'(acc_q);
    assign d_ext   = SUM_BW'(d);
    assign sum     = acc_ext + d_ext;

    always_comb begin
        acc_nxt = sum[ACC_BW-1:0];
        if (sum > SUM_MAX) begin
            acc_nxt = ACC_MAX;
        end else if (sum < SUM_MIN) begin
            acc_nxt = ACC_MIN;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q  <= ACC_INIT;
            coef_q <= COEF_INIT;
        end else if (i_restart) begin
            acc_q  <= ACC_INIT;
            coef_q <= COEF_INIT;
        end else begin
            if (i_upd) begin
                acc_q <= acc_nxt;
            end
            coef_q <= acc_q[ACC_BW-1:ACC_EXT];
        end
    end

    assign o_coef = coef_q;

endmodule

// File: rtl/ffe_lms_adapt.sv
// LMS adaptation downstream of the FFE: delay line, PAM2 slicer, TRAIN/TRACK FSM and per-tap updates.
// Define LMS_SIGN_SIGN_EN for the sign-sign update in place of the full-product LMS.
module ffe_lms_adapt
    import ffe_pkg::*;
#(
    parameter int IN_BW      = 11,
    parameter int OUT_BW     = 9,
    parameter int COEF_BW    = 9,
    parameter int N_COEF     = 7,
    parameter int ACC_EXT    = 8,
    parameter int MU_TRAIN   = MU_TRAIN_DEF,
    parameter int MU_TRACK   = MU_TRACK_DEF,
    parameter int TRAIN_LEN  = 1024,
    parameter int CENTER_TAP = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [IN_BW-1:0]           i_data,
    input  logic [OUT_BW-1:0]          i_ffe_out,
    input  logic                       i_adapt_en,
    input  logic                       i_restart,
    output logic [COEF_BW*N_COEF-1:0]  o_coefs,
    output logic [OUT_BW:0]            o_error,
    output logic [1:0]                 o_state,
    output logic                       o_trained
);

    localparam int CNT_BW = $clog2(TRAIN_LEN + 1);
    localparam logic signed [OUT_BW:0] SYM_POS = (OUT_BW+1)'(PAM2_POS);
    localparam logic signed [OUT_BW:0] SYM_NEG = (OUT_BW+1)'(PAM2_NEG);

    lms_state_t state_q, state_d;

    logic [CNT_BW-1:0]        train_cnt_q;
    logic                     trained_q;
    logic signed [IN_BW-1:0]  dly_q  [1:N_COEF-1];
    logic signed [IN_BW-1:0]  taps   [N_COEF];
    logic signed [IN_BW-1:0]  snap_q [N_COEF];
    logic                     v1_q;
    logic                     train_mode_q;
    logic signed [OUT_BW:0]   err_q, err_d, ffe_ext, sym;
    logic                     capture, cnt_done;

    always_comb begin
        taps[0] = $signed(i_data);
        for (int unsigned k = 1; k < N_COEF; k++) begin
            taps[k] = dly_q[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 1; k < N_COEF; k++) begin
                dly_q[k] <= '0;
            end
        end else if (i_en) begin
            dly_q[1] <= $signed(i_data);
            for (int unsigned k = 2; k < N_COEF; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    assign ffe_ext = (OUT_BW+1)'($signed(i_ffe_out));
    assign sym     = i_ffe_out[OUT_BW-1] ? SYM_NEG : SYM_POS;
    assign err_d   = sym - ffe_ext;

    assign capture  = i_en && i_adapt_en && !i_restart && is_adapting(state_q);
    assign cnt_done = v1_q && !trained_q && (train_cnt_q == CNT_BW'(TRAIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = i_adapt_en ? ST_TRAIN : ST_HOLD;
            ST_TRAIN: begin
                if (!i_adapt_en) begin
                    state_d = ST_HOLD;
                end else if (cnt_done) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!i_adapt_en) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // An update still in flight may be the one that completes training.
                if (i_adapt_en) begin
                    state_d = (trained_q || cnt_done) ? ST_TRACK : ST_TRAIN;
                end
            end
            default:  state_d = ST_INIT;
        endcase
        if (i_restart) begin
            state_d = ST_INIT;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            train_cnt_q <= '0;
            trained_q   <= 1'b0;
        end else if (i_restart) begin
            train_cnt_q <= '0;
            trained_q   <= 1'b0;
        end else if (v1_q && !trained_q) begin
            train_cnt_q <= train_cnt_q + 1'b1;
            if (cnt_done) begin
                trained_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q         <= 1'b0;
            train_mode_q <= 1'b0;
            err_q        <= '0;
            for (int unsigned k = 0; k < N_COEF; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            v1_q <= capture;
            if (capture) begin
                err_q        <= err_d;
                train_mode_q <= (state_q == ST_TRAIN);
                snap_q       <= taps;
            end
        end
    end

    for (genvar k = 0; k < N_COEF; k++) begin : g_tap
        lms_tap_update #(
            .IN_BW    (IN_BW),
            .OUT_BW   (OUT_BW),
            .COEF_BW  (COEF_BW),
            .ACC_EXT  (ACC_EXT),
            .MU_TRAIN (MU_TRAIN),
            .MU_TRACK (MU_TRACK),
            .INIT_ONE (k == CENTER_TAP)
        ) u_tap (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_restart (i_restart),
            .i_upd     (v1_q),
            .i_train   (train_mode_q),
            .i_err     (err_q),
            .i_x       (snap_q[k]),
            .o_coef    (o_coefs[COEF_BW*k +: COEF_BW])
        );
    end

    assign o_error   = err_q;
    assign o_state   = state_q;
    assign o_trained = trained_q;

endmodule

// File: tb/tb_ffe_lms_adapt.sv
// Scoreboard bench for ffe_lms_adapt: an integer reference model predicts every output per clock.
module tb_ffe_lms_adapt;

    localparam int IN_BW = 11, OUT_BW = 9, COEF_BW = 9, N_COEF = 7, ACC_EXT = 8;
    localparam int MU_TRAIN = 6, MU_TRACK = 9, TRAIN_LEN = 1024, CENTER_TAP = 3;
    localparam int ACC_MAXI = 65535, ACC_MINI = -65536;

    logic clk = 1'b0;
    logic rst, en, adapt, restart;
    logic [IN_BW-1:0]          data;
    logic [OUT_BW-1:0]         ffe;
    logic [COEF_BW*N_COEF-1:0] coefs;
    logic [OUT_BW:0]           err;
    logic [1:0]                st;
    logic                      trained;

    always #5 clk = ~clk;

    ffe_lms_adapt #(
        .IN_BW(IN_BW), .OUT_BW(OUT_BW), .COEF_BW(COEF_BW), .N_COEF(N_COEF),
        .ACC_EXT(ACC_EXT), .MU_TRAIN(MU_TRAIN), .MU_TRACK(MU_TRACK),
        .TRAIN_LEN(TRAIN_LEN), .CENTER_TAP(CENTER_TAP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_ffe_out(ffe),
        .i_adapt_en(adapt), .i_restart(restart), .o_coefs(coefs),
        .o_error(err), .o_state(st), .o_trained(trained)
    );

    typedef struct {
        logic [COEF_BW*N_COEF-1:0] coefs;
        logic [1:0]                st;
        logic                      tr;
        logic [OUT_BW:0]           err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    // Reference model: states 0=INIT 1=TRAIN 2=TRACK 3=HOLD, values as plain integers.
    int m_acc[N_COEF], m_coef[N_COEF], m_pd[N_COEF], m_hist[N_COEF-1];
    int m_st, m_cnt, m_err;
    bit m_tr, m_pv;

    function automatic int floordiv(input int a, input int b);
        int q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clampacc(input int v);
        if (v > ACC_MAXI) return ACC_MAXI;
        if (v < ACC_MINI) return ACC_MINI;
        return v;
    endfunction

    function automatic int delta(input int e, input int x, input int mu);
`ifdef LMS_SIGN_SIGN_EN
        if (e == 0 || x == 0) return 0;
        return ((e < 0) != (x < 0)) ? -(1 << (ACC_EXT + 7 - mu)) : (1 << (ACC_EXT + 7 - mu));
`else
        return floordiv(2 * e * x, 1 << mu);
`endif
    endfunction

    function automatic void model_init_coefs();
        for (int k = 0; k < N_COEF; k++) begin
            m_acc[k]  = (k == CENTER_TAP) ? (128 << ACC_EXT) : 0;
            m_coef[k] = (k == CENTER_TAP) ? 128 : 0;
        end
    endfunction

    function automatic void model_reset();
        model_init_coefs();
        for (int k = 0; k < N_COEF-1; k++) m_hist[k] = 0;
        m_st = 0; m_cnt = 0; m_err = 0; m_tr = 0; m_pv = 0;
    endfunction

    function automatic void model_step(input bit e_en, input int d, input int f, input bit a, input bit r);
        int taps[N_COEF];
        bit done = 0;
        int e, mu;
        taps[0] = d;
        for (int k = 1; k < N_COEF; k++) taps[k] = m_hist[k-1];
        if (r) begin
            model_init_coefs();
            m_cnt = 0; m_tr = 0; m_pv = 0; m_st = 0;
        end else begin
            for (int k = 0; k < N_COEF; k++) m_coef[k] = floordiv(m_acc[k], 1 << ACC_EXT);
            if (m_pv) begin
                for (int k = 0; k < N_COEF; k++) m_acc[k] = clampacc(m_acc[k] + m_pd[k]);
                if (!m_tr) begin
                    m_cnt++;
                    if (m_cnt == TRAIN_LEN) begin m_tr = 1; done = 1; end
                end
            end
            if (e_en && a && (m_st == 1 || m_st == 2)) begin
                e = ((f >= 0) ? 128 : -128) - f;
                mu = (m_st == 1) ? MU_TRAIN : MU_TRACK;
                m_err = e;
                m_pv = 1;
                for (int k = 0; k < N_COEF; k++) m_pd[k] = delta(e, taps[k], mu);
            end else begin
                m_pv = 0;
            end
            case (m_st)
                0: m_st = a ? 1 : 3;
                1: if (!a) m_st = 3; else if (done) m_st = 2;
                2: if (!a) m_st = 3;
                default: if (a) m_st = m_tr ? 2 : 1;
            endcase
        end
        if (e_en) begin
            for (int k = N_COEF-2; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = d;
        end
    endfunction

    function automatic logic [COEF_BW*N_COEF-1:0] model_bus();
        logic [COEF_BW*N_COEF-1:0] b;
        for (int k = 0; k < N_COEF; k++) b[COEF_BW*k +: COEF_BW] = COEF_BW'(m_coef[k]);
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit e_en, input int d, input int f, input bit a, input bit r);
        exp_t x;
        @(negedge clk);
        en = e_en; data = IN_BW'(d); ffe = OUT_BW'(f); adapt = a; restart = r;
        model_step(e_en, d, f, a, r);
        x.coefs = model_bus();
        x.st    = 2'(m_st);
        x.tr    = m_tr;
        x.err   = (OUT_BW+1)'(m_err);
        sbq.push_back(x);
    endtask

    task automatic check_reset_values(input string tag);
        logic [COEF_BW*N_COEF-1:0] ib;
        ib = '0;
        ib[COEF_BW*CENTER_TAP +: COEF_BW] = 9'd128;
        check({tag, "_coefs"},   64'(coefs),   64'(ib));
        check({tag, "_state"},   64'(st),      64'd0);
        check({tag, "_trained"}, 64'(trained), 64'd0);
        check({tag, "_error"},   64'(err),     64'd0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                check("coefs",   64'(coefs),   64'(x.coefs));
                check("state",   64'(st),      64'(x.st));
                check("trained", 64'(trained), 64'(x.tr));
                check("error",   64'(err),     64'(x.err));
            end
        end
    end

    initial begin : stim
        int s;
        rst = 1'b1; en = 1'b0; adapt = 1'b0; restart = 1'b0; data = '0; ffe = '0;
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk); #3; rst = 1'b0;

        // Adaptation disabled: HOLD with the initial coefficient pattern.
        repeat (100) cyc(1'b1, $urandom_range(0, 2047) - 1024, $urandom_range(0, 511) - 256, 1'b0, 1'b0);

        // Constant x = 64, FFE out = 100: e = 28, d = 56 per tap per update.
        repeat (7) cyc(1'b1, 64, 100, 1'b0, 1'b0);
        cyc(1'b0, 64, 100, 1'b0, 1'b1);
        repeat (40) cyc(1'b1, 64, 100, 1'b1, 1'b0);

        // Restart while an update is pending, then resume training.
        cyc(1'b1, 64, 100, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 64, 100, 1'b1, 1'b0);

        // Saturation at both accumulator limits.
        cyc(1'b1, -1024, 255, 1'b1, 1'b1);
        repeat (60) cyc(1'b1, -1024, 255, 1'b1, 1'b0);
        repeat (60) cyc(1'b1, -1024, -256, 1'b1, 1'b0);

        // Ideal channel: zero error, training completes after TRAIN_LEN updates.
        cyc(1'b1, 128, 128, 1'b1, 1'b1);
        repeat (2000) begin
            s = ($urandom_range(0, 1) == 1) ? 128 : -128;
            cyc(1'b1, s, s, 1'b1, 1'b0);
        end
        check("ideal_trained", 64'(m_tr), 64'd1);

        // Asynchronous reset in the middle of a clock period while tracking.
        @(posedge clk); #3;
        check("queue_drained_a", 64'(sbq.size()), 64'd0);
        rst = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(posedge clk); #3; rst = 1'b0;

        // Randomised traffic with gaps, freezes and occasional restarts.
        repeat (2500) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2047) - 1024,
                $urandom_range(0, 511) - 256, $urandom_range(0, 15) != 0,
                $urandom_range(0, 999) == 0);
        end

        @(posedge clk); #3;
        check("queue_drained_b", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ffe_lms_adapt.md
Name: ffe_lms_adapt

Overview:
- Adaptation stage directly downstream of the FFE.
- Consumes the FFE output sample and an identical copy of the FFE input stream. Slices the output to a PAM2 decision and forms the error.
- Runs an LMS update on N_COEF coefficient accumulators. Drives the FFE coefficient bus (CN..C0 packing, C0 in the LSBs).
- Number formats: data S(11,7), FFE out S(9,7), coefs S(9,7).

Parameters:
- IN_BW, 11, FFE input sample width, S(IN_BW,7).
- OUT_BW, 9, FFE output width, S(OUT_BW,7).
- COEF_BW, 9, coefficient width, S(COEF_BW,7).
- N_COEF, 7, number of taps.
- ACC_EXT, 8, extra fractional bits kept in each coefficient accumulator.
- MU_TRAIN, 6, step-size right shift during TRAIN.
- MU_TRACK, 9, step-size right shift during TRACK.
- TRAIN_LEN, 1024, number of updates spent in TRAIN.
- CENTER_TAP, 3, index of the tap initialised to 1.0.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  sample enable; same strobe that drives the FFE.
- i_data  in  IN_BW  FFE input sample (same net as FFE i_data).
- i_ffe_out  in  OUT_BW  FFE o_data for the current sample.
- i_adapt_en  in  1  1 = adapt, 0 = freeze coefficients.
- i_restart  in  1  synchronous pulse; reinitialises the coefficients and restarts TRAIN.
- o_coefs  out  COEF_BW*N_COEF  coefficient bus to the FFE; tap k occupies [COEF_BW*(k+1)-1 : COEF_BW*k].
- o_error  out  OUT_BW+1  last registered error, S(10,7).
- o_state  out  2  0=INIT, 1=TRAIN, 2=TRACK, 3=HOLD.
- o_trained  out  1  high once TRAIN_LEN updates have completed.

Behaviour:
- Reset (async) values:
  - all accumulators 0, except CENTER_TAP = 1.0, i.e. 128<<ACC_EXT;
  - o_coefs = center tap 128, all others 0;
  - o_error = 0, o_state = INIT, o_trained = 0;
  - delay line, pipeline valid bits and train counter all 0.
- Delay line: mirrors the FFE exactly.
  - x0 = i_data (combinational).
  - x[k] shifts on i_en.
  - Sample t therefore pairs i_ffe_out(t) with x0..x[N-1](t).
- Slicer: sym = +128 if i_ffe_out >= 0, else -128. e = sym - i_ffe_out, computed at OUT_BW+1 bits with no overflow.
- Stage 1, on a clock with i_en and state in {TRAIN, TRACK}: register e into o_error, snapshot the N taps, set v1 = 1. Otherwise v1 = 0.
- Stage 2, when v1 = 1:
  - g_k = e*x_k, S(21,14).
  - d_k = (g_k <<< 1) >>> mu (arithmetic, floor); mu = MU_TRAIN in TRAIN, MU_TRACK in TRACK.
  - acc_k = saturate(acc_k + d_k) to S(COEF_BW+ACC_EXT, 7+ACC_EXT).
- o_coefs[k] = acc_k >>> ACC_EXT (truncation); always registered.
- Latency: sample at cycle t → coefficient change visible on o_coefs at t+2.
- FSM:
  - INIT → TRAIN on the first clock after reset deassertion, if i_adapt_en = 1; otherwise INIT → HOLD.
  - TRAIN: the counter increments per stage-2 update. The update that brings it to TRAIN_LEN goes → TRACK and sets o_trained.
  - TRAIN/TRACK → HOLD when i_adapt_en = 0. Stage 1 stops immediately; an in-flight stage-2 update still completes.
  - HOLD → TRACK if o_trained, else → TRAIN with the counter preserved, when i_adapt_en = 1.
  - i_restart from any state → INIT on the next clock: accumulators reloaded, counter and o_trained cleared, v1 cleared, in-flight update dropped. i_restart has priority over i_adapt_en and over a pending update.
- Saturation boundary: an acc already at its max with positive d_k holds max; likewise at min with negative d_k. There is no wrap.
- i_en = 0: no shift, no stage-1 capture. Stage 2 still completes a pending v1.

Optional Feature:
- Macro: LMS_SIGN_SIGN_EN.
- Defined: d_k = ±(1 << (ACC_EXT+7-mu)) by sign(e) XOR sign(x_k). d_k = 0 if e == 0 or x_k == 0. No multipliers are inferred.
- Undefined: the full-product LMS described above.

Decomposition:
- Package ffe_pkg: format constants (FRAC_BITS = 7), PAM2 levels (+128/-128), state encoding, default mu shifts.
- Sub-module lms_tap_update: one per tap, containing the multiply (or sign logic), shift, saturating accumulator and truncated output. Instantiated by generate in ffe_lms_adapt. The top holds the FSM, delay line and slicer.

Test Plan:
- Reset, then i_adapt_en = 0 → o_coefs has tap3 = 128 and others 0; o_state = HOLD; o_coefs unchanged after 100 i_en strobes.
- i_ffe_out = 100, x = {all 64}, TRAIN (mu = 6) → e = 28, g = 1792, d = 56 per tap; every acc moves by +56 at t+2, and tap3 acc = 32768+56.
- Ideal channel (i_ffe_out = 128×sign(x0), x0 = ±128, other taps 0) → e = 0, o_coefs constant for 2000 samples; o_trained rises after update 1024 and o_state goes 1→2.
- Accumulator preloaded near max (tap at 255) with persistent positive d_k → o_coefs tap holds 255, never wraps to a negative value.
- i_restart asserted mid-TRAIN on the same cycle a stage-2 update is pending → update dropped, o_coefs back to the init pattern at next clock, counter 0, o_state = INIT then TRAIN.
- Async i_rst pulse mid-clock-period during TRACK → outputs reach reset values without waiting for a clock edge. With LMS_SIGN_SIGN_EN, the scenario-2 stimulus gives d = +512 per update.
